store_narrow_unit: RTL and testbench
====================================

// Module: store_narrow_unit
// PURPOSE
//  MEM-stage store path of the pipelined CPU, the inverse of load-side widening:
//  narrows a 32-bit register value to a byte, halfword or word write into data memory.
//  Builds lane-replicated write data and byte enables, and runs a req/ack handshake.
//  Stalls the pipeline until the write is acknowledged or faults.
// PARAMETERS
//  ADDR_W       32   byte-address width of st_addr_i / mem_addr_o
//  ACK_TIMEOUT  16   max cycles mem_req_o may wait for mem_ack_i; 0 = never time out
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       asynchronous reset, active-low
//  st_valid_i   in   1       MEM stage holds a store
//  st_size_i    in   2       00 byte, 01 half, 10 word, 11 reserved
//  st_addr_i    in   ADDR_W  byte address of the store
//  st_data_i    in   32      rt register value; low bits are the payload
//  stall_o      out  1       freeze IF..MEM pipeline registers
//  done_o       out  1       1-cycle pulse: write acknowledged
//  fault_o      out  1       1-cycle pulse: misaligned/reserved size/timeout
//  mem_req_o    out  1       write request to data memory
//  mem_addr_o   out  ADDR_W  word-aligned address ({st_addr_i[ADDR_W-1:2],2'b00})
//  mem_wdata_o  out  32      lane-replicated write data
//  mem_be_o     out  4       byte enables, bit i = byte lane i (little-endian)
//  mem_ack_i    in   1       memory accepted the write; sampled only while mem_req_o=1
// BEHAVIOUR
//  Reset (rst_i=0, async): state IDLE, timeout counter 0; all registered outputs
//  (done_o, fault_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o) are 0 immediately.
//  Narrowing (computed from inputs in IDLE, registered on accept):
//   byte: wdata={4{d[7:0]}},  be=4'b0001<<a[1:0]; never misaligned
//   half: wdata={2{d[15:0]}}, be=a[1]?4'b1100:4'b0011; misaligned if a[0]=1
//   word: wdata=d,            be=4'b1111; misaligned if a[1:0]!=0
//   size 11 is always a fault
//  FSM states: IDLE, REQ, DONE, FAULT.
//   IDLE: st_valid_i=1 and legal -> latch addr/wdata/be, go REQ (accept cycle).
//         st_valid_i=1 and illegal -> go FAULT; no memory request is ever issued.
//   REQ:  mem_req_o=1, with addr/wdata/be held stable.
//         mem_ack_i=1 -> DONE; counter reaches ACK_TIMEOUT -> FAULT (request dropped).
//   DONE: done_o=1 for exactly one cycle -> IDLE. st_valid_i is ignored (same store).
//   FAULT: fault_o=1 for exactly one cycle -> IDLE. st_valid_i is ignored.
//  stall_o (combinational) = (IDLE & st_valid_i) | REQ. It is 0 in DONE and FAULT, so
//   the pipeline advances at the end of that cycle.
//  Latency: mem_req_o rises 1 cycle after accept. An ack in the first REQ cycle is
//   legal; the minimum store costs 3 cycles (accept, REQ, DONE).
//  Timeout counter: cleared on entering REQ, +1 per REQ cycle without ack. An ack in
//   the same cycle the limit is reached wins (DONE, no fault).
//  Back-to-back stores: the next store is accepted in the first IDLE cycle after
//   DONE/FAULT. mem_ack_i outside REQ is ignored.
//  Reset mid-REQ: mem_req_o drops asynchronously; no done_o or fault_o for that store.
// TESTING
//  1 byte: size=00 addr=0x1003 data=0x12345678, ack after 1 cycle -> mem_addr_o=0x1000,
//    be=1000, wdata=0x78787878, stall_o 1 for 2 cycles, done_o pulse, no fault.
//  2 half: size=01 addr=0x0102 data=0xAABBCCDD, ack delayed 3 cycles -> be=1100,
//    wdata=0xCCDDCCDD, req held stable 4 cycles, stall_o high 5 cycles, single done_o.
//  3 misaligned: size=10 addr=0x0101, then size=01 addr=0x0003 -> each gives one fault_o
//    pulse and stall_o for 1 cycle; mem_req_o never rises.
//  4 timeout: ACK_TIMEOUT=4, word at 0x0040, ack never -> mem_req_o high 4 cycles,
//    then fault_o pulse and IDLE; a late ack is ignored.
//  5 reset mid-op: drop rst_i during REQ -> mem_req_o, be, wdata go 0 with no clock
//    edge; after release with st_valid_i=0 the unit stays idle.
//  6 back-to-back: two word stores with ack in the first REQ cycle -> req pulses are
//    3 cycles apart, 2 done_o pulses, DONE cycle never re-accepts.

Source files
------------

// File: rtl/store_narrow_unit.sv
// MEM-stage store narrowing: turns a register value into a lane-replicated memory write
// with byte enables, issues it over a req/ack handshake and stalls the pipeline meanwhile.
module store_narrow_unit #(
   parameter int ADDR_W      = 32,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              st_valid_i,
   input  logic [1:0]        st_size_i,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [31:0]       st_data_i,
   output logic              stall_o,
   output logic              done_o,
   output logic              fault_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_be_o,
   input  logic              mem_ack_i
);

   localparam int CNT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = (ACK_TIMEOUT < 1) ? '0 : CNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                done_q;
   logic                fault_q;
   logic                req_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [3:0]          be_q;

   logic [ADDR_W-1:0]   addr_d;
   logic [31:0]         wdata_d;
   logic [3:0]          be_d;
   logic                legal_d;
   logic                limit_hit;

   always_comb begin
      addr_d  = {st_addr_i[ADDR_W-1:2], 2'b00};
      wdata_d = st_data_i;
      be_d    = 4'b1111;
      legal_d = 1'b1;
      case (st_size_i)
         2'b00: begin
            wdata_d = {4{st_data_i[7:0]}};
            be_d    = 4'b0001 << st_addr_i[1:0];
         end
         2'b01: begin
            wdata_d = {2{st_data_i[15:0]}};
            be_d    = st_addr_i[1] ? 4'b1100 : 4'b0011;
            legal_d = ~st_addr_i[0];
         end
         2'b10: begin
            legal_d = (st_addr_i[1:0] == 2'b00);
         end
         default: begin
            be_d    = 4'b0000;
            legal_d = 1'b0;
         end
      endcase
   end

   // The counter holds the number of unacknowledged REQ cycles already spent.
   assign limit_hit = (ACK_TIMEOUT != 0) && (cnt_q == LAST_CNT);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (st_valid_i) begin
                  if (legal_d) begin
                     addr_q  <= addr_d;
                     wdata_q <= wdata_d;
                     be_q    <= be_d;
                     req_q   <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= REQ;
                  end else begin
                     fault_q <= 1'b1;
                     state_q <= FAULT;
                  end
               end
            end
            REQ: begin
               if (mem_ack_i) begin
                  req_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (limit_hit) begin
                  req_q   <= 1'b0;
                  fault_q <= 1'b1;
                  state_q <= FAULT;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            DONE:    state_q <= IDLE;
            FAULT:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall_o     = ((state_q == IDLE) && st_valid_i) || (state_q == REQ);
   assign done_o      = done_q;
   assign fault_o     = fault_q;
   assign mem_req_o   = req_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = be_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: directed scenarios plus randomized stores checked
// against an arithmetic model of narrowing, legality and handshake timing.
module tb_store_narrow_unit;
   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        st_valid_i = 1'b0;
   logic [1:0]  st_size_i = '0;
   logic [31:0] st_addr_i = '0;
   logic [31:0] st_data_i = '0;
   logic        mem_ack_i = 1'b0;
   logic        stall_o, done_o, fault_o, mem_req_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;

   store_narrow_unit #(.ADDR_W(32), .ACK_TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .st_valid_i(st_valid_i), .st_size_i(st_size_i),
      .st_addr_i(st_addr_i), .st_data_i(st_data_i), .stall_o(stall_o), .done_o(done_o),
      .fault_o(fault_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   int cmp_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   always @(posedge clk_i) cyc++;

   // Observations gathered by run_store for the last store.
   int          o_stall, o_req, o_done, o_fault, o_first_req, o_unstable, o_post_req;
   logic [31:0] o_addr, o_wdata;
   logic [3:0]  o_be;

   // Expected narrowing result from the size/alignment rules.
   function automatic void model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                 output bit legal, output logic [31:0] w, output logic [3:0] be);
      case (sz)
         2'd0: begin legal = 1; w = d[7:0] * 32'h0101_0101; be = 4'(1 << (a % 4)); end
         2'd1: begin legal = (a % 2 == 0); w = d[15:0] * 32'h0001_0001; be = (a % 4 >= 2) ? 4'hC : 4'h3; end
         2'd2: begin legal = (a % 4 == 0); w = d; be = 4'hF; end
         default: begin legal = 0; w = '0; be = '0; end
      endcase
   endfunction

   // Called at (or just after) a falling edge. ack_after = number of REQ cycles that pass
   // without ack before ack is given; negative means never.
   task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input int ack_after);
      o_stall = 0; o_req = 0; o_done = 0; o_fault = 0; o_first_req = -1;
      o_unstable = 0; o_post_req = 0; o_addr = '0; o_wdata = '0; o_be = '0;
      st_valid_i = 1'b1; st_size_i = sz; st_addr_i = a; st_data_i = d; mem_ack_i = 1'b0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (stall_o) o_stall++;
         if (mem_req_o) begin
            if (o_req == 0) begin
               o_first_req = cyc; o_addr = mem_addr_o; o_wdata = mem_wdata_o; o_be = mem_be_o;
            end else if ({mem_addr_o, mem_wdata_o, mem_be_o} !== {o_addr, o_wdata, o_be}) begin
               o_unstable++;
            end
            mem_ack_i = (o_req == ack_after);
            o_req++;
         end else begin
            mem_ack_i = 1'($urandom_range(0, 1));
         end
         if (done_o) o_done++;
         if (fault_o) o_fault++;
         if (done_o || fault_o) begin
            @(negedge clk_i); #1;
            o_post_req = int'(mem_req_o);
            o_done += int'(done_o);
            o_fault += int'(fault_o);
            break;
         end
         @(negedge clk_i);
      end
      st_valid_i = 1'b0; mem_ack_i = 1'b0;
      $display("store size=%0d addr=%h data=%h ack_after=%0d: req=%0d stall=%0d done=%0d fault=%0d be=%b wdata=%h",
               sz, a, d, ack_after, o_req, o_stall, o_done, o_fault, o_be, o_wdata);
   endtask

   task automatic test_reset;
      rst_i = 1'b0;
      #3;
      cmp_cnt++; if ({mem_req_o, done_o, fault_o, stall_o} !== 4'b0) begin err_cnt++;
         $display("FAIL reset_ctrl: got %b want 0000", {mem_req_o, done_o, fault_o, stall_o}); end
      cmp_cnt++; if ({mem_addr_o, mem_wdata_o, mem_be_o} !== 68'h0) begin err_cnt++;
         $display("FAIL reset_data: got %h/%h/%b want 0", mem_addr_o, mem_wdata_o, mem_be_o); end
      @(negedge clk_i); rst_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_byte;
      run_store(2'b00, 32'h1003, 32'h1234_5678, 0);
      cmp_cnt++; if (o_addr !== 32'h1000) begin err_cnt++; $display("FAIL byte_addr: got %h want 1000", o_addr); end
      cmp_cnt++; if (o_be !== 4'b1000) begin err_cnt++; $display("FAIL byte_be: got %b want 1000", o_be); end
      cmp_cnt++; if (o_wdata !== 32'h7878_7878) begin err_cnt++; $display("FAIL byte_wdata: got %h want 78787878", o_wdata); end
      cmp_cnt++; if (o_stall !== 2) begin err_cnt++; $display("FAIL byte_stall: got %0d want 2", o_stall); end
      cmp_cnt++; if (o_done !== 1 || o_fault !== 0) begin err_cnt++;
         $display("FAIL byte_pulses: got done=%0d fault=%0d want 1/0", o_done, o_fault); end
   endtask

   task automatic test_half;
      run_store(2'b01, 32'h0102, 32'hAABB_CCDD, 3);
      cmp_cnt++; if (o_be !== 4'b1100) begin err_cnt++; $display("FAIL half_be: got %b want 1100", o_be); end
      cmp_cnt++; if (o_wdata !== 32'hCCDD_CCDD) begin err_cnt++; $display("FAIL half_wdata: got %h want ccddccdd", o_wdata); end
      cmp_cnt++; if (o_req !== 4 || o_unstable !== 0) begin err_cnt++;
         $display("FAIL half_req: got req=%0d unstable=%0d want 4/0", o_req, o_unstable); end
      cmp_cnt++; if (o_stall !== 5) begin err_cnt++; $display("FAIL half_stall: got %0d want 5", o_stall); end
      cmp_cnt++; if (o_done !== 1 || o_fault !== 0) begin err_cnt++;
         $display("FAIL half_pulses: got done=%0d fault=%0d want 1/0", o_done, o_fault); end
   endtask

   task automatic test_misaligned;
      logic [1:0]  sz [2] = '{2'b10, 2'b01};
      logic [31:0] ad [2] = '{32'h0101, 32'h0003};
      for (int i = 0; i < 2; i++) begin
         run_store(sz[i], ad[i], $urandom, 0);
         cmp_cnt++; if (o_fault !== 1 || o_done !== 0) begin err_cnt++;
            $display("FAIL misal%0d_pulses: got fault=%0d done=%0d want 1/0", i, o_fault, o_done); end
         cmp_cnt++; if (o_stall !== 1 || o_req !== 0) begin err_cnt++;
            $display("FAIL misal%0d_stall_req: got stall=%0d req=%0d want 1/0", i, o_stall, o_req); end
      end
   endtask

   task automatic test_timeout;
      int late = 0;
      run_store(2'b10, 32'h0040, $urandom, -1);
      cmp_cnt++; if (o_req !== TO) begin err_cnt++; $display("FAIL timeout_req: got %0d want %0d", o_req, TO); end
      cmp_cnt++; if (o_fault !== 1 || o_done !== 0) begin err_cnt++;
         $display("FAIL timeout_pulses: got fault=%0d done=%0d want 1/0", o_fault, o_done); end
      for (int k = 0; k < 4; k++) begin
         mem_ack_i = 1'b1;
         @(negedge clk_i); #1;
         late += int'(mem_req_o) + int'(done_o) + int'(fault_o);
      end
      mem_ack_i = 1'b0;
      cmp_cnt++; if (late !== 0) begin err_cnt++; $display("FAIL late_ack: got %0d events want 0", late); end
   endtask

   task automatic test_reset_mid;
      int seen = 0;
      int after = 0;
      @(negedge clk_i);
      st_valid_i = 1'b1; st_size_i = 2'b10; st_addr_i = 32'h0080; st_data_i = 32'hDEAD_BEEF; mem_ack_i = 1'b0;
      for (int k = 0; k < 5 && !seen; k++) begin
         @(negedge clk_i); #1;
         seen = int'(mem_req_o);
      end
      cmp_cnt++; if (seen !== 1) begin err_cnt++; $display("FAIL rstmid_req_rise: got %0d want 1", seen); end
      #1 rst_i = 1'b0;
      #1;
      cmp_cnt++; if ({mem_req_o, mem_be_o, mem_wdata_o} !== 37'h0) begin err_cnt++;
         $display("FAIL rstmid_clear: got req=%b be=%b wdata=%h want 0", mem_req_o, mem_be_o, mem_wdata_o); end
      st_valid_i = 1'b0;
      @(negedge clk_i); rst_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i); #1;
         after += int'(mem_req_o) + int'(done_o) + int'(fault_o) + int'(stall_o);
      end
      cmp_cnt++; if (after !== 0) begin err_cnt++; $display("FAIL rstmid_idle: got %0d events want 0", after); end
      @(negedge clk_i);
   endtask

   task automatic test_back_to_back;
      int r1, d1;
      run_store(2'b10, 32'h0200, $urandom, 0);
      r1 = o_first_req; d1 = o_done;
      cmp_cnt++; if (o_post_req !== 0) begin err_cnt++; $display("FAIL b2b_reaccept: got req=%0d after done want 0", o_post_req); end
      run_store(2'b10, 32'h0204, $urandom, 0);
      cmp_cnt++; if (o_first_req - r1 !== 3) begin err_cnt++;
         $display("FAIL b2b_spacing: got %0d cycles want 3", o_first_req - r1); end
      cmp_cnt++; if (d1 + o_done !== 2) begin err_cnt++; $display("FAIL b2b_done: got %0d want 2", d1 + o_done); end
      cmp_cnt++; if (o_addr !== 32'h0204) begin err_cnt++; $display("FAIL b2b_addr: got %h want 204", o_addr); end
   endtask

   task automatic test_random;
      bit          legal;
      logic [31:0] ew, a, d;
      logic [3:0]  eb;
      logic [1:0]  sz;
      int          ack_after, e_done, e_fault, e_req, e_stall;
      for (int n = 0; n < 24; n++) begin
         sz = 2'($urandom_range(0, 3)); a = $urandom; d = $urandom;
         ack_after = $urandom_range(0, 5);
         model(sz, a, d, legal, ew, eb);
         if (!legal) begin e_done = 0; e_fault = 1; e_req = 0; e_stall = 1; end
         else if (ack_after < TO) begin e_done = 1; e_fault = 0; e_req = ack_after + 1; e_stall = ack_after + 2; end
         else begin e_done = 0; e_fault = 1; e_req = TO; e_stall = TO + 1; end
         run_store(sz, a, d, ack_after);
         cmp_cnt++; if (o_done !== e_done || o_fault !== e_fault) begin err_cnt++;
            $display("FAIL rnd%0d_pulses: got done=%0d fault=%0d want %0d/%0d", n, o_done, o_fault, e_done, e_fault); end
         cmp_cnt++; if (o_req !== e_req || o_stall !== e_stall) begin err_cnt++;
            $display("FAIL rnd%0d_timing: got req=%0d stall=%0d want %0d/%0d", n, o_req, o_stall, e_req, e_stall); end
         cmp_cnt++; if (o_post_req !== 0) begin err_cnt++; $display("FAIL rnd%0d_post: got req=%0d want 0", n, o_post_req); end
         if (legal) begin
            cmp_cnt++; if (o_addr !== (a & ~32'h3) || o_be !== eb || o_wdata !== ew || o_unstable !== 0) begin err_cnt++;
               $display("FAIL rnd%0d_write: got %h/%b/%h unstable=%0d want %h/%b/%h", n, o_addr, o_be, o_wdata,
                        o_unstable, a & ~32'h3, eb, ew); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_byte;
      test_half;
      test_misaligned;
      test_timeout;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish within 200000 time units, want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
